// File: rtl/sram_word_sequencer.sv
// sram_word_sequencer: moves one 32-bit word over a 16-bit async SRAM as a low and a high halfword phase.
module sram_word_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    state_t state;
    logic [3:0] cnt;
    logic op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic req, act, last, unused_addr;
    assign req = wr_en | rd_en;
    assign last = cnt == LAST;
    // rst gates the bus immediately so an aborted write never sees another strobe
    assign act = !rst && (state == LOW || state == HIGH);
    assign ready = rst || state == DONE || (state == IDLE && !req);
    assign SRAM_ADDR = act ? {idx, state == HIGH} : '0;
    assign SRAM_WE_N = !(act && op_wr && !last);
    assign SRAM_OE_N = !(act && !op_wr);
    assign SRAM_DQ = (act && op_wr) ? (state == HIGH ? wdata[31:16] : wdata[15:0]) : 'z;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign unused_addr = ^{address[31:19], address[1:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            read_data <= '0;
            op_wr <= 1'b0;
            idx <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_wr <= wr_en;
                    idx <= address[18:2];
                    wdata <= write_data;
                    cnt <= '0;
                    state <= LOW;
                end
                LOW, HIGH: if (last) begin
                    cnt <= '0;
                    state <= state == LOW ? HIGH : DONE;
                    if (!op_wr && state == LOW) read_data[15:0] <= SRAM_DQ;
                    if (!op_wr && state == HIGH) read_data[31:16] <= SRAM_DQ;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
